// File: rtl/mem_stream_reader.sv
// Streams one DEPTH-byte message out of a synchronous-read memory through a
// 2-entry skid FIFO with valid/ready handshake and a running byte sum.
module mem_stream_reader #(
   parameter int unsigned DEPTH  = 512,
   parameter int unsigned ADDR_W = 9,
   parameter int unsigned SUM_W  = 13
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              re,
   output logic [ADDR_W-1:0] indirizzo_read,
   input  logic [7:0]        mem_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [7:0]        out_data,
   output logic              out_last,
   output logic              busy,
   output logic              fine,
   output logic [SUM_W-1:0]  somma
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   state_t            state;
   logic [ADDR_W-1:0] addr;
   logic              rd_pend;
   logic              rd_pend_last;
   logic [7:0]        fifo_data [2];
   logic              fifo_last [2];
   logic              wr_ptr;
   logic              rd_ptr;
   logic [1:0]        count;
   logic [1:0]        credit;
   logic              push;
   logic              pop;

   assign push           = rd_pend;
   assign pop            = out_valid & out_ready;
   assign out_valid      = (count != 2'd0);
   assign out_data       = fifo_data[rd_ptr];
   assign out_last       = fifo_last[rd_ptr];
   assign busy           = (state != IDLE);
   assign fine           = (state == DONE);
   assign indirizzo_read = addr;

   // A new read is allowed only if, after this cycle's pop, buffered plus
   // in-flight bytes leave room for it; using the pop keeps 1 byte/cycle.
   always_comb begin
      credit = count + 2'(rd_pend) - 2'(pop);
      re     = (state == READ) && (credit < 2'd2);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         addr         <= '0;
         rd_pend      <= 1'b0;
         rd_pend_last <= 1'b0;
         fifo_data[0] <= '0;
         fifo_data[1] <= '0;
         fifo_last[0] <= 1'b0;
         fifo_last[1] <= 1'b0;
         wr_ptr       <= 1'b0;
         rd_ptr       <= 1'b0;
         count        <= '0;
         somma        <= '0;
      end else begin
         rd_pend      <= re;
         rd_pend_last <= re && (addr == LAST_ADDR);

         if (push) begin
            fifo_data[wr_ptr] <= mem_data;
            fifo_last[wr_ptr] <= rd_pend_last;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
            somma  <= somma + SUM_W'(out_data);
         end
         count <= count + 2'(push) - 2'(pop);

         case (state)
            IDLE: begin
               if (start) begin
                  state <= READ;
                  addr  <= '0;
                  somma <= '0;
               end
            end
            READ: begin
               if (re) begin
                  if (addr == LAST_ADDR) state <= DRAIN;
                  else                   addr  <= addr + ADDR_W'(1);
               end
            end
            DRAIN: begin
               if (pop && out_last) state <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Scoreboard bench for mem_stream_reader: stimulus queues expected bytes and
// sums, an independent negedge monitor pops and compares on each transfer.
module tb_mem_stream_reader;

   localparam int unsigned DEPTH  = 512;
   localparam int unsigned ADDR_W = 9;
   localparam int unsigned SUM_W  = 13;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              re;
   logic [ADDR_W-1:0] indirizzo_read;
   logic [7:0]        mem_data = 8'd0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [7:0]        out_data;
   logic              out_last;
   logic              busy;
   logic              fine;
   logic [SUM_W-1:0]  somma;

   logic [7:0] mem [DEPTH];
   logic [8:0] exp_q [$];
   int         sum_q [$];

   int n_cmp = 0, n_err = 0;
   int cyc = 0, issued = 0, n_xfer = 0, max_occ = 0, occ = 0;
   int e0 = 0, last_cyc = 0, fine_cyc = 0, ready_mode = 0, nre = 0;
   logic       stall_prev = 1'b0;
   logic [7:0] stall_data = 8'd0;
   logic [8:0] ev;

   mem_stream_reader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .SUM_W(SUM_W)) dut (
      .clk(clk), .reset(reset), .start(start), .re(re),
      .indirizzo_read(indirizzo_read), .mem_data(mem_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .busy(busy), .fine(fine), .somma(somma)
   );

   always #5 clk = ~clk;

   // Synchronous-read memory: data appears in the cycle after re.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (re) mem_data <= mem[indirizzo_read];
   end

   always @(posedge clk or negedge reset) begin
      if (!reset)  issued <= 0;
      else if (re) issued <= issued + 1;
   end

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic fail_line(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: actual=none required=event", name);
   endtask

   task automatic fill(input int pat);
      for (int i = 0; i < int'(DEPTH); i++) mem[i] = (pat == 0) ? 8'(i) : 8'hFF;
   endtask

   task automatic push_msg(input int sum);
      for (int i = 0; i < int'(DEPTH); i++) exp_q.push_back({(i == int'(DEPTH) - 1), mem[i]});
      sum_q.push_back(sum);
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      e0 = cyc;
   endtask

   task automatic wait_fine();
      int k;
      for (k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (fine) break;
      end
      if (k == 3000) fail_line("fine_timeout");
   endtask

   // Ready pattern driver: 0 = always ready, 1 = toggle, 2 = never ready.
   initial forever begin
      @(posedge clk); #2;
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = ~out_ready;
         default: out_ready = 1'b0;
      endcase
   end

   // Monitor: checks every transfer, stall stability, occupancy and sums.
   initial forever begin
      @(negedge clk);
      if (!reset) begin
         n_xfer     = 0;
         stall_prev = 1'b0;
      end else begin
         occ = issued + int'(re) - n_xfer - int'(out_valid && out_ready);
         if (occ > max_occ) max_occ = occ;
         if (stall_prev && out_valid) check("stall_hold", int'(out_data), int'(stall_data));
         stall_prev = out_valid && !out_ready;
         stall_data = out_data;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) fail_line("unexpected_byte");
            else begin
               ev = exp_q.pop_front();
               check("byte", int'({out_last, out_data}), int'(ev));
            end
            if (out_last) last_cyc = cyc;
            n_xfer++;
         end
         if (fine) begin
            fine_cyc = cyc;
            if (sum_q.size() == 0) fail_line("unexpected_fine");
            else check("somma", int'(somma), sum_q.pop_front());
         end
      end
   end

   initial begin
      fill(0);
      #2 reset = 1'b0;
      #10;
      check("reset_ctl", int'({re, out_valid, out_last, busy, fine}), 0);
      check("reset_data", int'({indirizzo_read, out_data, somma}), 0);
      @(posedge clk); #1 reset = 1'b1;

      // Incrementing pattern, always ready: latency and throughput.
      push_msg(7936);
      pulse_start();
      @(negedge clk); check("e0_busy_re_valid", int'({busy, re, out_valid}), 3'b110);
      @(negedge clk); check("e1_valid", int'(out_valid), 0);
      @(negedge clk); check("e2_valid", int'(out_valid), 1);
      wait_fine();
      @(negedge clk);
      check("last_latency", last_cyc - e0, 513);
      check("fine_latency", fine_cyc - e0, 514);
      check("fine_pulse", int'({fine, busy}), 0);
      repeat (5) @(negedge clk);
      check("somma_hold", int'(somma), 7936);

      // All 0xFF: sum wraps.
      fill(1);
      push_msg(7680);
      pulse_start();
      wait_fine();
      @(negedge clk);

      // Toggling ready.
      fill(0);
      ready_mode = 1;
      push_msg(7936);
      pulse_start();
      wait_fine();
      ready_mode = 0;
      @(negedge clk);

      // Long stall right after start.
      ready_mode = 2;
      push_msg(7936);
      pulse_start();
      nre = 0;
      repeat (20) begin
         @(negedge clk);
         nre += int'(re);
      end
      check("stall_reads", nre, 2);
      check("stall_valid", int'(out_valid), 1);
      ready_mode = 0;
      wait_fine();
      @(negedge clk);

      // Reset in the middle of a message, then a clean replay.
      push_msg(7936);
      pulse_start();
      begin
         int k;
         for (k = 0; k < 2000; k++) begin
            @(posedge clk);
            if (n_xfer >= 100) break;
         end
         if (k == 2000) fail_line("xfer100_timeout");
      end
      #3 reset = 1'b0;
      #1;
      check("abort_ctl", int'({re, out_valid, out_last, busy, fine}), 0);
      check("abort_data", int'({indirizzo_read, out_data, somma}), 0);
      exp_q.delete();
      sum_q.delete();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      push_msg(7936);
      pulse_start();
      wait_fine();
      @(negedge clk);

      // Start pulsed mid-read is ignored.
      push_msg(7936);
      pulse_start();
      repeat (50) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_fine();
      @(negedge clk);

      // Start held high across DONE restarts right after IDLE.
      push_msg(7936);
      push_msg(7936);
      @(posedge clk); #1 start = 1'b1;
      wait_fine();
      @(negedge clk); check("done_to_idle", int'(busy), 0);
      @(negedge clk); check("restart_busy_re", int'({busy, re}), 2'b11);
      check("restart_addr", int'(indirizzo_read), 0);
      @(posedge clk); #1 start = 1'b0;
      wait_fine();
      @(negedge clk);

      check("max_occupancy_le2", int'(max_occ <= 2), 1);
      check("queue_empty", exp_q.size() + sum_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
